// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-domain consumer of the async FIFO. Pops entries from a
// first-word-fall-through port, packs PACK lanes into one output word and
// presents it on a valid/ready stream with a lane-keep mask. A flush request
// emits the current partial word.
// Optional build macro PACKER_FLUSH_TIMEOUT_EN adds an idle timer that raises an
// internal flush after FLUSH_CYCLES idle cycles with a partial word held.
module fifo_rd_packer #(
  parameter int DATA_SIZE    = 8,
  parameter int PACK         = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rstn,
  input  logic                      rd_empty,
  input  logic [DATA_SIZE-1:0]      rd_data,
  output logic                      rd_inc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_SIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]           out_keep,
  output logic [15:0]               word_cnt
);

  localparam int IW = $clog2(PACK);
  localparam logic [IW-1:0] LAST = IW'(PACK - 1);

  // Reject parameter sets the lane index or idle timer cannot represent.
  if (PACK < 2 || PACK > 16 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 65535) begin : g_bad_param
    $error("fifo_rd_packer: parameter out of range");
  end

  logic [DATA_SIZE-1:0]      r_acc [PACK];
  logic [IW-1:0]             r_idx;
  logic                      r_flush_pend;
  logic                      r_out_valid;
  logic [DATA_SIZE*PACK-1:0] r_out_data;
  logic [PACK-1:0]           r_out_keep;
  logic [15:0]               r_word_cnt;

  logic                      w_out_free;
  logic                      w_pop;
  logic                      w_word_done;
  logic                      w_service;
  logic                      w_xfer;
  logic                      w_timeout;
  logic [DATA_SIZE*PACK-1:0] w_full_data;
  logic [DATA_SIZE*PACK-1:0] w_part_data;
  logic [PACK-1:0]           w_part_keep;

  // The last lane may only be popped when the output register can take the word;
  // a pending flush freezes popping so the partial word is cut cleanly.
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_pop       = rd_rstn && !rd_empty && !r_flush_pend && (r_idx != LAST || w_out_free);
  assign w_word_done = w_pop && (r_idx == LAST);
  assign w_service   = r_flush_pend && (r_idx != '0) && w_out_free;
  assign w_xfer      = r_out_valid && out_ready;

  // Build the full word (head entry fills the top lane) and the zero-padded partial word.
  always_comb begin
    w_full_data = '0;
    w_part_data = '0;
    w_part_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i == PACK - 1) begin
        w_full_data[i*DATA_SIZE +: DATA_SIZE] = rd_data;
      end else begin
        w_full_data[i*DATA_SIZE +: DATA_SIZE] = r_acc[i];
      end
      if (IW'(i) < r_idx) begin
        w_part_data[i*DATA_SIZE +: DATA_SIZE] = r_acc[i];
        w_part_keep[i]                        = 1'b1;
      end
    end
  end

`ifdef PACKER_FLUSH_TIMEOUT_EN
  logic [15:0] r_idle_tmr;

  // Idle down-timer: reloads on any pop or when no lanes are held, expires at zero.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_idle_tmr <= 16'(FLUSH_CYCLES);
    end else if (r_idx == '0 || w_pop) begin
      r_idle_tmr <= 16'(FLUSH_CYCLES);
    end else if (r_idle_tmr != '0) begin
      r_idle_tmr <= r_idle_tmr - 16'd1;
    end
  end

  assign w_timeout = (r_idx != '0) && (r_idle_tmr == '0);
`else
  assign w_timeout = 1'b0;
`endif

  // Accumulate popped lanes below the top lane.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      for (int i = 0; i < PACK; i++) r_acc[i] <= '0;
    end else if (w_pop && !w_word_done) begin
      r_acc[r_idx] <= rd_data;
    end
  end

  // Lane index advances per pop and returns to lane 0 on word completion or flush.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_idx <= '0;
    end else if (w_pop) begin
      r_idx <= w_word_done ? '0 : r_idx + IW'(1);
    end else if (w_service) begin
      r_idx <= '0;
    end
  end

  // Sticky flush request; dropped once serviced or when there is nothing to flush.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_flush_pend <= 1'b0;
    end else begin
      r_flush_pend <= flush || w_timeout || (r_flush_pend && !w_service && r_idx != '0);
    end
  end

  // One-entry output register: load a full or flushed word, clear valid on transfer.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
    end else if (w_word_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_full_data;
      r_out_keep  <= '1;
    end else if (w_service) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_part_data;
      r_out_keep  <= w_part_keep;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count accepted words, wrapping at 16 bits.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_word_cnt <= '0;
    end else if (w_xfer) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign rd_inc    = w_pop;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: FIFO and expected words modelled at lane-list level.
module tb_fifo_rd_packer;
  localparam int DS = 8;
  localparam int PK = 4;
  localparam int FC = 16;
  localparam int OW = DS * PK;

  typedef logic [PK+OW-1:0] word_t;  // {keep, data}

  logic          rd_clk = 1'b0;
  logic          rd_rstn = 1'b0;
  logic          rd_empty = 1'b1;
  logic [DS-1:0] rd_data = '0;
  logic          rd_inc;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [PK-1:0] out_keep;
  logic [15:0]   word_cnt;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int exp_total = 0;

  logic [DS-1:0] fifo_q[$];
  logic [DS-1:0] lanes_q[$];
  word_t         exp_q[$];
  word_t         got_q[$];

  fifo_rd_packer #(.DATA_SIZE(DS), .PACK(PK), .FLUSH_CYCLES(FC)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_inc(rd_inc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .word_cnt(word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic upd_fifo();
    rd_empty = (fifo_q.size() == 0);
    rd_data  = rd_empty ? '0 : fifo_q[0];
  endtask

  // Model: emit the currently collected lanes as one word (low lanes first).
  task automatic emit();
    word_t w = '0;
    for (int i = 0; i < lanes_q.size(); i++) begin
      w[i*DS +: DS] = lanes_q[i];
      w[OW+i]       = 1'b1;
    end
    exp_q.push_back(w);
    exp_total++;
    lanes_q.delete();
  endtask

  task automatic push(input logic [DS-1:0] x);
    fifo_q.push_back(x);
    lanes_q.push_back(x);
    if (lanes_q.size() == PK) emit();
    upd_fifo();
  endtask

  task automatic model_flush();
    if (lanes_q.size() > 0) emit();
  endtask

  // One clock: sample at negedge, apply FIFO pop effect 1 time unit after posedge.
  task automatic tick();
    logic p;
    @(negedge rd_clk);
    p = rd_inc;
    if (out_valid && out_ready) got_q.push_back({out_keep, out_data});
    @(posedge rd_clk);
    #1;
    if (p) begin
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    upd_fifo();
  endtask

  task automatic settle(input int max, output bit ok);
    ok = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < max; k++) begin
      if (fifo_q.size() == 0 && got_q.size() >= exp_q.size() && !out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rd_rstn = 1'b0;
    rd_empty = 1'b0;
    rd_data = 8'h5A;
    #1;
    checks++; if (rd_inc !== 1'b0) begin failures++; $display("FAIL reset_rd_inc got=%b exp=0", rd_inc); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_keep !== '0) begin failures++; $display("FAIL reset_keep got=%b exp=0", out_keep); end
    checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    upd_fifo();
    @(posedge rd_clk); #1;
    rd_rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h44332211) begin failures++; $display("FAIL basic_data got=%h exp=44332211", out_data); end
    checks++; if (out_keep !== 4'b1111) begin failures++; $display("FAIL basic_keep got=%b exp=1111", out_keep); end
    settle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_settle got=timeout exp=idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (word_cnt !== 16'(exp_total)) begin failures++; $display("FAIL basic_word_cnt got=%0d exp=%0d", word_cnt, exp_total); end
  endtask

  task automatic test_flush();
    bit ok;
    out_ready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (5) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_hold got=%b exp=0", out_valid); end
    model_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_latency got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h00A3A2A1) begin failures++; $display("FAIL flush_data got=%h exp=00a3a2a1", out_data); end
    checks++; if (out_keep !== 4'b0111) begin failures++; $display("FAIL flush_keep got=%b exp=0111", out_keep); end
    for (int i = 0; i < PK; i++) push(8'($urandom));
    settle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL flush_settle got=timeout exp=idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL flush_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 3 * PK; i++) push(8'($urandom));
    repeat (20) tick();
    checks++; if (pops != PK + PK - 1) begin failures++; $display("FAIL bp_pops got=%0d exp=%0d", pops, 2 * PK - 1); end
    checks++; if (rd_inc !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", rd_inc); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_held_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== exp_q[0][OW-1:0]) begin failures++; $display("FAIL bp_held_data got=%h exp=%h", out_data, exp_q[0][OW-1:0]); end
    settle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_settle got=timeout exp=idle"); end
    checks++; if (pops != 3 * PK) begin failures++; $display("FAIL bp_total_pops got=%0d exp=%0d", pops, 3 * PK); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush_on_last_pop();
    out_ready = 1'b1;
    for (int i = 0; i < PK; i++) push(8'($urandom));
    repeat (PK - 1) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
    repeat (8) tick();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL flast_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL flast_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (word_cnt !== 16'(exp_total)) begin failures++; $display("FAIL flast_word_cnt got=%0d exp=%0d", word_cnt, exp_total); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < PK + 2; i++) push(8'($urandom));
    repeat (PK + 2) tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
    rd_rstn = 1'b0;
    #1;
    checks++; if ({out_valid, out_keep, out_data, word_cnt, rd_inc} !== '0)
      begin failures++; $display("FAIL rmid_outputs got=%b/%b/%h/%0d/%b exp=0", out_valid, out_keep, out_data, word_cnt, rd_inc); end
    exp_q.delete(); lanes_q.delete(); got_q.delete(); fifo_q.delete();
    exp_total = 0;
    upd_fifo();
    @(posedge rd_clk); #1;
    rd_rstn = 1'b1;
    for (int i = 0; i < PK; i++) push(8'($urandom));
    settle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_settle got=timeout exp=idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (word_cnt !== 16'd1) begin failures++; $display("FAIL rmid_word_cnt got=%0d exp=1", word_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(1, 10));
      for (int k = 0; k < 200 && (n > 0 || fifo_q.size() > 0); k++) begin
        if (n > 0 && $urandom_range(0, 2) != 0) begin
          push(8'($urandom));
          n--;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      if ($urandom_range(0, 1) == 1) begin
        model_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end
    model_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_settle got=timeout exp=idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (word_cnt !== 16'(exp_total)) begin failures++; $display("FAIL rand_word_cnt got=%0d exp=%0d", word_cnt, exp_total); end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    out_ready = 1'b1;
    push(8'h5C);
    tick();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) break;
      tick();
      cnt++;
    end
`ifdef PACKER_FLUSH_TIMEOUT_EN
    checks++; if (cnt != FC + 2) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", cnt, FC + 2); end
    checks++; if (out_keep !== 4'b0001) begin failures++; $display("FAIL tmo_keep got=%b exp=0001", out_keep); end
    model_flush();
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tmo_no_output got=%b exp=0 (cycles=%0d)", out_valid, cnt); end
    checks++; if (rd_inc !== 1'b0) begin failures++; $display("FAIL tmo_rd_inc got=%b exp=0", rd_inc); end
    model_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
`endif
    settle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_settle got=timeout exp=idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL tmo_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL tmo_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_flush_on_last_pop();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. It pops DATA_SIZE-bit entries from the FIFO's first-word-fall-through read port and packs PACK consecutive entries into one wide word. The word is presented on a valid/ready output stream with a byte-keep mask. Partial words can be flushed on request.

## Interface
- DATA_SIZE, 8, width of one FIFO entry (one "lane").
- PACK, 4, lanes per output word (2..16).
- FLUSH_CYCLES, 16, idle-cycle threshold for auto-flush. Used only with PACKER_FLUSH_TIMEOUT_EN.

Ports:
- rd_clk  in  1  read-domain clock. Single clock for the whole block.
- rd_rstn  in  1  reset, asynchronous, active-low.
- rd_empty  in  1  FIFO empty flag.
- rd_data  in  DATA_SIZE  FIFO head entry. Valid combinationally whenever rd_empty=0.
- rd_inc  out  1  pop strobe to the FIFO.
- flush  in  1  request to emit the current partial word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_SIZE*PACK  packed word. Lane 0 occupies the LSBs.
- out_keep  out  PACK  lane-valid mask.
- word_cnt  out  16  count of accepted output words.

## Operation
- State:
  - accumulator acc[PACK-1:0]
  - lane index idx (0..PACK-1)
  - sticky flush_pend
  - one-entry output register (out_valid, out_data, out_keep)
- out_free = !out_valid || out_ready.
- rd_inc = !rd_empty && !flush_pend && (idx != PACK-1 || out_free). rd_inc is forced to 0 while rd_rstn=0.
- Pop, idx<PACK-1:
  - acc[idx] <= rd_data
  - idx <= idx+1
- Pop, idx==PACK-1 (word complete):
  - out_data <= {rd_data, acc[PACK-2:0]}
  - out_keep <= all ones
  - out_valid <= 1
  - idx <= 0
- Flush:
  - The flush pulse sets flush_pend. It stays set until serviced.
  - Serviced when flush_pend && idx!=0 && out_free:
    - out_data <= acc lanes [idx-1:0], with unused lanes zero
    - out_keep <= (1<<idx)-1
    - out_valid <= 1
    - idx <= 0
    - flush_pend <= 0
  - flush_pend with idx==0 clears in the next cycle with no output.
- Flush and word-completing pop in the same cycle: rd_inc is already 0 if flush_pend was set. Otherwise the pop completes a full word, and the newly set flush_pend then sees idx==0 and clears.
- Output handshake: the word transfers when out_valid && out_ready. out_valid deasserts after transfer unless a new word loads in the same cycle.
- word_cnt increments on each transfer and wraps 0xFFFF->0x0000.
- Reset mid-operation discards accumulated lanes, the pending flush and any held output word.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_keep=0, word_cnt=0
  - idx=0, flush_pend=0
  - rd_inc=0
- rd_inc is combinational. rd_data is sampled on the rd_clk edge where rd_inc=1.
- Latency: the final lane popped at edge N gives out_valid=1 after edge N.
- Flush latency:
  - flush sampled at edge N sets flush_pend.
  - The partial word is loaded at the first later edge with out_free. With out_free=1 it is valid after edge N+1.
- Throughput: one lane per cycle. With out_ready held 1 and FIFO never empty, one word every PACK cycles with no bubbles.
- Backpressure: with out_valid=1 and out_ready=0, popping continues up to idx=PACK-1, then stalls. No entry is lost or duplicated.

## Configuration
- PACKER_FLUSH_TIMEOUT_EN defined:
  - A 16-bit idle counter counts cycles with idx!=0 and rd_inc=0.
  - It resets to 0 on any pop or when idx==0.
  - On reaching FLUSH_CYCLES it sets flush_pend internally, with the same service rules as flush.
- Not defined: no counter. A partial word is held until completed or an external flush.

## Test plan
- PACK=4, push 0x11,0x22,0x33,0x44 with out_ready=1 -> one word 0x44332211, out_keep=4'b1111, word_cnt=1.
- Push 3 entries 0xA1,0xA2,0xA3, then pulse flush -> word 0x00A3A2A1, keep=4'b0111. The next entries start at lane 0.
- out_ready=0, push 12 entries -> first word held. Exactly 3 further pops occur, then rd_inc stays 0. Releasing out_ready delivers 3 words in order.
- flush asserted on the same edge as the 4th-lane pop -> one full word, keep=4'b1111, no extra empty word.
- rd_rstn pulsed low after 2 entries with out_valid=1 -> all outputs 0 immediately. After release the next 4 entries form a fresh word.
- With PACKER_FLUSH_TIMEOUT_EN and FLUSH_CYCLES=16: 1 entry, then FIFO empty -> partial word with keep=4'b0001, valid 18 cycles after the pop. Without the macro, no output.
